// File: rtl/fetch_ref_load_ctrl_if.sv
// -----------------------------------------------------------------------------
// fetch_ref_load_ctrl_if
// Bundles the two bus ports of the reference-strip load sequencer:
//   * frame-memory read client: mem_req_o/mem_ack_i request handshake with
//     mem_x_o/mem_y_o row coordinates, in-order mem_rvalid_i/mem_rdata_i data
//   * reference buffer write port: ext_load_valid_o/addr_o/data_o row writes
//     and the ext_load_done_o strip-complete pulse
// Signal suffixes are from the sequencer's point of view.
// Modports: master = sequencer, slave = memory/buffer side.
// -----------------------------------------------------------------------------
interface fetch_ref_load_ctrl_if #(
  parameter int PIC_X_WIDTH = 8,
  parameter int PIXEL_WIDTH = 8
);
  logic                       mem_req_o;
  logic                       mem_ack_i;
  logic [PIC_X_WIDTH-1:0]     mem_x_o;
  logic [12:0]                mem_y_o;
  logic                       mem_rvalid_i;
  logic [96*PIXEL_WIDTH-1:0]  mem_rdata_i;
  logic                       ext_load_valid_o;
  logic [6:0]                 ext_load_addr_o;
  logic [96*PIXEL_WIDTH-1:0]  ext_load_data_o;
  logic                       ext_load_done_o;

  modport master (
    output mem_req_o, mem_x_o, mem_y_o,
    input  mem_ack_i, mem_rvalid_i, mem_rdata_i,
    output ext_load_valid_o, ext_load_addr_o, ext_load_data_o, ext_load_done_o
  );

  modport slave (
    input  mem_req_o, mem_x_o, mem_y_o,
    output mem_ack_i, mem_rvalid_i, mem_rdata_i,
    input  ext_load_valid_o, ext_load_addr_o, ext_load_data_o, ext_load_done_o
  );
endinterface

// File: rtl/fetch_ref_load_ctrl.sv
// -----------------------------------------------------------------------------
// fetch_ref_load_ctrl
// Load sequencer for the triple-buffered luma reference window. Each start
// fetches one ROWS x 96-pixel strip (TOP_OFS rows above the LCU top edge,
// vertically clamped to the picture) from frame memory and writes the rows,
// in order, into the buffer bank selected for writing.
//
// Ports:
//   clk, rstn            clock, asynchronous active-low reset
//   sysif_start_i        start pulse (ignored with overrun_o when not idle)
//   lcu_x_i, lcu_y_i     LCU coordinates, latched on start
//   pic_height_i         picture height in pixels (>=1), latched on start
//   bus (master)         frame-memory request/response + buffer write port
//   busy_o               strip load in progress
//   err_o                pulse: response arrived with nothing outstanding
//   overrun_o            pulse: start seen while not idle
//   load_cycles_o        (FETCH_REF_LOAD_PERF_EN only) saturating start-to-done
//                        cycle count
//
// Optional feature macro: FETCH_REF_LOAD_PERF_EN
// -----------------------------------------------------------------------------
module fetch_ref_load_ctrl #(
  parameter int ROWS        = 80,
  parameter int TOP_OFS     = 16,
  parameter int MAX_OUT     = 4,
  parameter int PIC_X_WIDTH = 8,
  parameter int PIC_Y_WIDTH = 8,
  parameter int PIXEL_WIDTH = 8
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic                   sysif_start_i,
  input  logic [PIC_X_WIDTH-1:0] lcu_x_i,
  input  logic [PIC_Y_WIDTH-1:0] lcu_y_i,
  input  logic [12:0]            pic_height_i,
  fetch_ref_load_ctrl_if.master  bus,
  output logic                   busy_o,
  output logic                   err_o,
  output logic                   overrun_o
`ifdef FETCH_REF_LOAD_PERF_EN
  ,
  output logic [15:0]            load_cycles_o
`endif
);

  localparam int                 DW        = 96 * PIXEL_WIDTH;
  localparam logic [6:0]         ROWS_C    = 7'(ROWS);
  localparam logic [6:0]         LAST_ROW  = 7'(ROWS - 1);
  localparam logic [6:0]         MAX_OUT_C = 7'(MAX_OUT);
  localparam logic signed [14:0] TOP_OFS_C = 15'(TOP_OFS);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_DRAIN, S_DONE} state_t;

  state_t                 r_state, w_state_nxt;
  logic [6:0]             r_issued, r_recv, w_issued_nxt, w_recv_nxt;
  logic [PIC_X_WIDTH-1:0] r_lcu_x;
  logic [PIC_Y_WIDTH-1:0] r_lcu_y, w_lcu_y;
  logic [12:0]            r_height, w_height;
  logic                   r_req, w_req_nxt;
  logic [12:0]            r_y, w_y_nxt;
  logic signed [14:0]     w_y_raw;
  logic                   r_wr_vld;
  logic [6:0]             r_wr_addr;
  logic [DW-1:0]          r_wr_data;
  logic                   r_done, r_busy, r_err, r_overrun;
  logic                   w_start, w_accept, w_resp;

  // Clamp a signed row index into [0, height-1].
  function automatic logic [12:0] clamp_row(input logic signed [14:0] y_raw,
                                            input logic [12:0]        height);
    logic [12:0] res;
    if (y_raw < 15'sd0)
      res = '0;
    else if (y_raw >= $signed({2'b00, height}))
      res = height - 13'd1;
    else
      res = y_raw[12:0];
    return res;
  endfunction

  always_comb begin
    w_state_nxt  = r_state;
    w_start      = sysif_start_i && (r_state == S_IDLE);
    w_accept     = r_req && bus.mem_ack_i;
    // A response is only a row write if something is actually outstanding.
    w_resp       = bus.mem_rvalid_i && ((r_state == S_REQ) || (r_state == S_DRAIN))
                   && (r_issued != r_recv);
    w_issued_nxt = w_start ? 7'd0 : r_issued + {6'd0, w_accept};
    w_recv_nxt   = w_start ? 7'd0 : r_recv + {6'd0, w_resp};

    case (r_state)
      S_IDLE:  if (w_start) w_state_nxt = S_REQ;
      S_REQ:   if (w_accept && (r_issued == LAST_ROW)) w_state_nxt = S_DRAIN;
      S_DRAIN: if (w_resp && (r_recv == LAST_ROW)) w_state_nxt = S_DONE;
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase

    // Request outputs are registered, so they are computed from the
    // next-cycle counters; on the start edge the live inputs are used.
    w_lcu_y   = w_start ? lcu_y_i : r_lcu_y;
    w_height  = w_start ? pic_height_i : r_height;
    w_y_raw   = $signed(15'(w_lcu_y) << 6) + $signed(15'(w_issued_nxt)) - TOP_OFS_C;
    w_y_nxt   = clamp_row(w_y_raw, w_height);
    w_req_nxt = (w_state_nxt == S_REQ) && (w_issued_nxt < ROWS_C)
                && ((w_issued_nxt - w_recv_nxt) < MAX_OUT_C);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state   <= S_IDLE;
      r_issued  <= '0;
      r_recv    <= '0;
      r_lcu_x   <= '0;
      r_lcu_y   <= '0;
      r_height  <= '0;
      r_req     <= 1'b0;
      r_y       <= '0;
      r_wr_vld  <= 1'b0;
      r_wr_addr <= '0;
      r_wr_data <= '0;
      r_done    <= 1'b0;
      r_busy    <= 1'b0;
      r_err     <= 1'b0;
      r_overrun <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_issued  <= w_issued_nxt;
      r_recv    <= w_recv_nxt;
      if (w_start) begin
        r_lcu_x  <= lcu_x_i;
        r_lcu_y  <= lcu_y_i;
        r_height <= pic_height_i;
      end
      r_req     <= w_req_nxt;
      r_y       <= w_y_nxt;
      r_wr_vld  <= w_resp;
      if (w_resp) begin
        r_wr_addr <= r_recv;
        r_wr_data <= bus.mem_rdata_i;
      end
      r_done    <= (r_state == S_DONE);
      r_busy    <= (w_state_nxt != S_IDLE);
      r_err     <= bus.mem_rvalid_i && !w_resp;
      r_overrun <= sysif_start_i && (r_state != S_IDLE);
    end
  end

`ifdef FETCH_REF_LOAD_PERF_EN
  logic [15:0] r_cycles;

  // Starts at 1 so the start cycle itself is included; frozen once idle.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)
      r_cycles <= '0;
    else if (w_start)
      r_cycles <= 16'd1;
    else if ((r_state != S_IDLE) && (r_cycles != 16'hFFFF))
      r_cycles <= r_cycles + 16'd1;
  end

  assign load_cycles_o = r_cycles;
`endif

  assign bus.mem_req_o        = r_req;
  assign bus.mem_x_o          = r_lcu_x;
  assign bus.mem_y_o          = r_y;
  assign bus.ext_load_valid_o = r_wr_vld;
  assign bus.ext_load_addr_o  = r_wr_addr;
  assign bus.ext_load_data_o  = r_wr_data;
  assign bus.ext_load_done_o  = r_done;
  assign busy_o               = r_busy;
  assign err_o                = r_err;
  assign overrun_o            = r_overrun;

endmodule

// File: tb/tb_fetch_ref_load_ctrl.sv
`timescale 1ns/1ps
module tb_fetch_ref_load_ctrl;
  localparam int DW = 768;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        sysif_start_i = 1'b0;
  logic [7:0]  lcu_x_i = '0;
  logic [7:0]  lcu_y_i = '0;
  logic [12:0] pic_height_i = 13'd1080;
  logic        busy_o, err_o, overrun_o;
`ifdef FETCH_REF_LOAD_PERF_EN
  logic [15:0] load_cycles_o;
`endif

  fetch_ref_load_ctrl_if #(.PIC_X_WIDTH(8), .PIXEL_WIDTH(8)) bus ();

  fetch_ref_load_ctrl dut (
    .clk           (clk),
    .rstn          (rstn),
    .sysif_start_i (sysif_start_i),
    .lcu_x_i       (lcu_x_i),
    .lcu_y_i       (lcu_y_i),
    .pic_height_i  (pic_height_i),
    .bus           (bus),
    .busy_o        (busy_o),
    .err_o         (err_o),
    .overrun_o     (overrun_o)
`ifdef FETCH_REF_LOAD_PERF_EN
    ,
    .load_cycles_o (load_cycles_o)
`endif
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Memory/buffer model state
  bit          model_en = 1'b0;
  bit          rnd_ack = 1'b0;
  bit          inject_stray = 1'b0;
  bit          stall_prev = 1'b0;
  bit          busy_at_done = 1'b0;
  int          fix_lat = 1;
  int          cyc = 0;
  int          acc_cnt = 0, rsp_cnt = 0, wr_cnt = 0;
  int          done_cnt = 0, err_seen = 0, ovr_seen = 0;
  int          done_cyc = 0, start_cyc = 0, last_due = 0, seq = 0;
  int          cur_x = 0, cur_ly = 0, cur_h = 1080;
  logic [12:0] y_prev = '0;
  int          due_q[$];
  logic [DW-1:0] dat_q[$];
  logic [DW-1:0] exp_q[$];

  function automatic int exp_y(input int k);
    int raw;
    raw = cur_ly * 64 + k - 16;
    if (raw < 0) return 0;
    if (raw >= cur_h) return cur_h - 1;
    return raw;
  endfunction

  function automatic logic [DW-1:0] pat(input int s, input int k);
    return {12{32'(s), 32'(k * 7 + 1)}};
  endfunction

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Runs once per cycle on the falling edge: observes the registered
  // outputs of the current cycle, then drives inputs for the next edge.
  task automatic model_step();
    int lat;
    int due;
    logic [DW-1:0] e;
    if (bus.ext_load_valid_o) begin
      chk("wr_addr", DW'(bus.ext_load_addr_o), DW'(wr_cnt));
      e = {DW{1'bx}};
      if (exp_q.size() != 0) e = exp_q.pop_front();
      chk("wr_data", bus.ext_load_data_o, e);
      wr_cnt++;
    end
    if (bus.ext_load_done_o) begin
      done_cnt++;
      done_cyc = cyc;
      busy_at_done = busy_o;
    end
    if (err_o) err_seen++;
    if (overrun_o) ovr_seen++;
    if (stall_prev) begin
      chk("req_hold", DW'(bus.mem_req_o), DW'(1));
      chk("y_hold", DW'(bus.mem_y_o), DW'(y_prev));
    end

    bus.mem_ack_i = rnd_ack ? 1'($urandom_range(0, 1)) : 1'b1;
    bus.mem_rvalid_i = 1'b0;
    if (inject_stray) begin
      bus.mem_rvalid_i = 1'b1;
      bus.mem_rdata_i = {24{32'hDEADBEEF}};
      inject_stray = 1'b0;
    end else if (due_q.size() != 0 && due_q[0] == cyc + 1) begin
      void'(due_q.pop_front());
      bus.mem_rvalid_i = 1'b1;
      bus.mem_rdata_i = dat_q.pop_front();
      exp_q.push_back(bus.mem_rdata_i);
      rsp_cnt++;
    end

    if (bus.mem_req_o && bus.mem_ack_i) begin
      chk("mem_y", DW'(bus.mem_y_o), DW'(exp_y(acc_cnt)));
      chk("mem_x", DW'(bus.mem_x_o), DW'(cur_x));
      lat = rnd_ack ? int'($urandom_range(1, 12)) : fix_lat;
      due = cyc + 1 + lat;
      if (due <= last_due) due = last_due + 1;
      last_due = due;
      due_q.push_back(due);
      dat_q.push_back(pat(seq, acc_cnt));
      acc_cnt++;
      chk("outstanding_le_4", DW'((acc_cnt - rsp_cnt) <= 4), DW'(1));
    end
    stall_prev = bus.mem_req_o && !bus.mem_ack_i;
    y_prev = bus.mem_y_o;
  endtask

  initial begin
    bus.mem_ack_i = 1'b0;
    bus.mem_rvalid_i = 1'b0;
    bus.mem_rdata_i = '0;
    forever begin
      @(negedge clk);
      if (model_en) model_step();
    end
  end

  task automatic start_load(input int x, input int y, input int h, input bit rnd, input int lat);
    @(negedge clk); #1;
    cur_x = x; cur_ly = y; cur_h = h; rnd_ack = rnd; fix_lat = lat; seq++;
    acc_cnt = 0; rsp_cnt = 0; wr_cnt = 0; done_cnt = 0; err_seen = 0; ovr_seen = 0;
    last_due = 0; stall_prev = 1'b0;
    due_q.delete(); dat_q.delete(); exp_q.delete();
    lcu_x_i = 8'(x); lcu_y_i = 8'(y); pic_height_i = 13'(h);
    sysif_start_i = 1'b1;
    start_cyc = cyc;
    @(posedge clk); #1;
    sysif_start_i = 1'b0;
    // Inputs are latched on start; scramble them to prove it.
    lcu_x_i = ~lcu_x_i; lcu_y_i = ~lcu_y_i; pic_height_i = 13'd5;
    chk("busy_after_start", DW'(busy_o), DW'(1));
    chk("req_first_cycle", DW'(bus.mem_req_o), DW'(1));
  endtask

  task automatic wait_done(input int budget, input string tag);
    int n = 0;
    while (done_cnt == 0 && n < budget) begin
      @(negedge clk); #1;
      n++;
    end
    chk(tag, DW'(done_cnt != 0), DW'(1));
    repeat (3) @(negedge clk);
    #1;
  endtask

  task automatic wait_writes(input int k, input int budget);
    int n = 0;
    while (wr_cnt < k && n < budget) begin
      @(negedge clk); #1;
      n++;
    end
    chk("wait_writes", DW'(wr_cnt >= k), DW'(1));
  endtask

  task automatic chk_load_end(input string tag);
    chk({tag, "_writes"}, DW'(wr_cnt), DW'(80));
    chk({tag, "_accepts"}, DW'(acc_cnt), DW'(80));
    chk({tag, "_done_pulses"}, DW'(done_cnt), DW'(1));
    chk({tag, "_busy_at_done"}, DW'(busy_at_done), DW'(0));
    chk({tag, "_busy_after"}, DW'(busy_o), DW'(0));
    chk({tag, "_no_err"}, DW'(err_seen), DW'(0));
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_req"}, DW'(bus.mem_req_o), DW'(0));
    chk({tag, "_x"}, DW'(bus.mem_x_o), DW'(0));
    chk({tag, "_y"}, DW'(bus.mem_y_o), DW'(0));
    chk({tag, "_wvld"}, DW'(bus.ext_load_valid_o), DW'(0));
    chk({tag, "_waddr"}, DW'(bus.ext_load_addr_o), DW'(0));
    chk({tag, "_wdata"}, bus.ext_load_data_o, DW'(0));
    chk({tag, "_done"}, DW'(bus.ext_load_done_o), DW'(0));
    chk({tag, "_busy"}, DW'(busy_o), DW'(0));
    chk({tag, "_err"}, DW'(err_o), DW'(0));
    chk({tag, "_ovr"}, DW'(overrun_o), DW'(0));
  endtask

  initial begin
    int e0, w0;
    model_en = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    chk_all_zero("reset");
`ifdef FETCH_REF_LOAD_PERF_EN
    chk("reset_cycles", DW'(load_cycles_o), DW'(0));
`endif
    rstn = 1'b1;

    // Normal load, read latency 3
    start_load(5, 2, 1080, 1'b0, 3);
    wait_done(400, "normal_done");
    chk_load_end("normal");
    chk("normal_start_to_done", DW'(done_cyc - start_cyc), DW'(85));
    chk("normal_no_overrun", DW'(ovr_seen), DW'(0));
`ifdef FETCH_REF_LOAD_PERF_EN
    chk("normal_load_cycles", DW'(load_cycles_o), DW'(85));
`endif

    // Top clamp, minimum latency
    start_load(1, 0, 1080, 1'b0, 1);
    wait_done(400, "top_done");
    chk_load_end("top");
    chk("top_start_to_done", DW'(done_cyc - start_cyc), DW'(83));

    // Bottom clamp
    start_load(7, 16, 1080, 1'b0, 2);
    wait_done(400, "bottom_done");
    chk_load_end("bottom");

    // Backpressure: random ack and latency 1..12
    start_load(3, 5, 1080, 1'b1, 0);
    wait_done(3000, "bp_done");
    chk_load_end("bp");

    // Start while busy at row 40
    start_load(2, 3, 1080, 1'b0, 3);
    wait_writes(40, 400);
    @(negedge clk); #1;
    lcu_y_i = 8'd9;
    sysif_start_i = 1'b1;
    @(posedge clk); #1;
    sysif_start_i = 1'b0;
    wait_done(400, "ovr_done");
    chk_load_end("ovr");
    chk("ovr_pulses", DW'(ovr_seen), DW'(1));

    // Stray response while idle
    repeat (2) @(negedge clk);
    #1;
    e0 = err_seen; w0 = wr_cnt;
    inject_stray = 1'b1;
    repeat (4) @(negedge clk);
    #1;
    chk("stray_err_pulse", DW'(err_seen), DW'(e0 + 1));
    chk("stray_no_write", DW'(wr_cnt), DW'(w0));

    // Reset at row 30
    start_load(4, 2, 1080, 1'b0, 3);
    wait_writes(30, 400);
    @(posedge clk); #1;
    model_en = 1'b0;
    rstn = 1'b0;
    #1;
    chk_all_zero("midreset");
    bus.mem_rvalid_i = 1'b0;
    bus.mem_ack_i = 1'b0;
    due_q.delete(); dat_q.delete(); exp_q.delete();
    stall_prev = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    rstn = 1'b1;
    model_en = 1'b1;
    start_load(6, 4, 1080, 1'b0, 3);
    wait_done(400, "post_reset_done");
    chk_load_end("post_reset");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
